parking_exit_controller: RTL and testbench

Exit-side controller for the car parking system. Entry allocations arrive from the allocating side of the same system. For each allocation the block records occupancy and an entry timestamp per spot. On an exit request it computes a duration-based fee, waits for payment, opens the exit barrier for a fixed window, then returns a one-hot release pulse that frees the spot.

---
 rtl/parking_exit_controller.sv | 154 +++++++++++++++
 tb/tb_parking_exit_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_exit_controller.sv
// Exit-side parking controller: tracks spot occupancy and entry time, charges a
// duration-based fee, waits for payment, drives the exit barrier and releases the spot.
module parking_exit_controller #(
  parameter int unsigned NUM_SPOTS   = 4,
  parameter int unsigned TS_WIDTH    = 16,
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned RATE        = 1,
  parameter int unsigned FEE_WIDTH   = 16,
  parameter int unsigned GATE_CYCLES = 8,
  parameter int unsigned PAY_TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  input  logic [$clog2(NUM_SPOTS)-1:0] alloc_spot,
  input  logic                         exit_req,
  input  logic [$clog2(NUM_SPOTS)-1:0] exit_spot,
  input  logic                         paid,
  output logic                         exit_busy,
  output logic [FEE_WIDTH-1:0]         fee,
  output logic                         fee_valid,
  output logic                         exit_error,
  output logic                         gate_open,
  output logic [NUM_SPOTS-1:0]         spot_release,
  output logic [NUM_SPOTS-1:0]         occupied
);

  localparam int unsigned SPOT_W  = $clog2(NUM_SPOTS);
  localparam int unsigned PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_MAX = (GATE_CYCLES > PAY_TIMEOUT) ? GATE_CYCLES : PAY_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PROD_W  = TS_WIDTH + 32;
  localparam logic [PROD_W-1:0] FEE_MAX = PROD_W'({FEE_WIDTH{1'b1}});

  typedef enum logic [2:0] {IDLE, CALC, WAIT_PAY, GATE, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [PS_W-1:0]      prescale_q;
  logic [TS_WIDTH-1:0]  now_q;
  logic [TS_WIDTH-1:0]  entry_ts [NUM_SPOTS];
  logic [SPOT_W-1:0]    spot_q, spot_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_d;
  logic                 release_d;
  logic [NUM_SPOTS-1:0] release_vec;
  logic [NUM_SPOTS-1:0] occ_d;
  logic                 alloc_take;
  logic [TS_WIDTH-1:0]  duration;
  logic [PROD_W-1:0]    product;
  logic [FEE_WIDTH-1:0] fee_calc;

  // Free-running timebase: now advances once per TICK_DIV clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
      now_q      <= '0;
    end else if (prescale_q == PS_W'(TICK_DIV - 1)) begin
      prescale_q <= '0;
      now_q      <= now_q + 1'b1;
    end else begin
      prescale_q <= prescale_q + 1'b1;
    end
  end

  // Fee: modular elapsed time times rate, multiplied at full width then saturated
  assign duration = now_q - entry_ts[spot_q];
  assign product  = PROD_W'(duration) * PROD_W'(RATE);
  assign fee_calc = (product > FEE_MAX) ? '1 : FEE_WIDTH'(product);

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    spot_d  = spot_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (exit_req) begin
          if (occupied[exit_spot]) begin
            spot_d  = exit_spot;
            state_d = CALC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CALC: begin
        cnt_d   = '0;
        state_d = (fee_calc == '0) ? GATE : WAIT_PAY;
      end
      WAIT_PAY: begin
        if (paid) begin
          cnt_d   = '0;
          state_d = GATE;
        end else if (cnt_q == CNT_W'(PAY_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == CNT_W'(GATE_CYCLES - 1)) state_d = RELEASE;
        else cnt_d = cnt_q + 1'b1;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    release_d   = (state_d == RELEASE);
    release_vec = release_d ? (NUM_SPOTS'(1) << spot_q) : '0;

    // A spot being released this cycle is free for a simultaneous allocation
    occ_d = occupied;
    if (release_d) occ_d[spot_q] = 1'b0;
    alloc_take = alloc_valid && !occ_d[alloc_spot];
    if (alloc_take) occ_d[alloc_spot] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      spot_q       <= '0;
      occupied     <= '0;
      exit_busy    <= 1'b0;
      fee          <= '0;
      fee_valid    <= 1'b0;
      exit_error   <= 1'b0;
      gate_open    <= 1'b0;
      spot_release <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      spot_q       <= spot_d;
      occupied     <= occ_d;
      exit_busy    <= (state_d != IDLE);
      fee_valid    <= (state_d == WAIT_PAY);
      exit_error   <= err_d;
      gate_open    <= (state_d == GATE);
      spot_release <= release_vec;
      if (state_q == CALC) fee <= fee_calc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPOTS; i++) entry_ts[i] <= '0;
    end else if (alloc_take) begin
      entry_ts[alloc_spot] <= now_q;
    end
  end

endmodule

// File: tb/tb_parking_exit_controller.sv
// Directed bench for parking_exit_controller; four instances share stimulus and
// differ in timestamp width, rate and tick divider.
module tb_parking_exit_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_valid = 1'b0;
  logic [1:0] alloc_spot = 2'd0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_spot = 2'd0;
  logic       paid = 1'b0;

  logic        m_busy, m_fee_valid, m_err, m_gate;
  logic [15:0] m_fee;
  logic [3:0]  m_rel, m_occ;
  logic        w_busy, w_fee_valid, w_err, w_gate;
  logic [15:0] w_fee;
  logic [3:0]  w_rel, w_occ;
  logic        s_busy, s_fee_valid, s_err, s_gate;
  logic [15:0] s_fee;
  logic [3:0]  s_rel, s_occ;
  logic        g_busy, g_fee_valid, g_err, g_gate;
  logic [15:0] g_fee;
  logic [3:0]  g_rel, g_occ;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Reference timebase for the TICK_DIV=2 instances: now = cyc/2
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  parking_exit_controller #(.NUM_SPOTS(4), .TS_WIDTH(16), .TICK_DIV(2), .RATE(3),
    .FEE_WIDTH(16), .GATE_CYCLES(3), .PAY_TIMEOUT(10)) u_main (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_spot(alloc_spot),
    .exit_req(exit_req), .exit_spot(exit_spot), .paid(paid), .exit_busy(m_busy),
    .fee(m_fee), .fee_valid(m_fee_valid), .exit_error(m_err), .gate_open(m_gate),
    .spot_release(m_rel), .occupied(m_occ));

  parking_exit_controller #(.NUM_SPOTS(4), .TS_WIDTH(4), .TICK_DIV(2), .RATE(3),
    .FEE_WIDTH(16), .GATE_CYCLES(3), .PAY_TIMEOUT(10)) u_wrap (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_spot(alloc_spot),
    .exit_req(exit_req), .exit_spot(exit_spot), .paid(paid), .exit_busy(w_busy),
    .fee(w_fee), .fee_valid(w_fee_valid), .exit_error(w_err), .gate_open(w_gate),
    .spot_release(w_rel), .occupied(w_occ));

  parking_exit_controller #(.NUM_SPOTS(4), .TS_WIDTH(16), .TICK_DIV(2), .RATE(20000),
    .FEE_WIDTH(16), .GATE_CYCLES(3), .PAY_TIMEOUT(10)) u_sat (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_spot(alloc_spot),
    .exit_req(exit_req), .exit_spot(exit_spot), .paid(paid), .exit_busy(s_busy),
    .fee(s_fee), .fee_valid(s_fee_valid), .exit_error(s_err), .gate_open(s_gate),
    .spot_release(s_rel), .occupied(s_occ));

  parking_exit_controller #(.NUM_SPOTS(4), .TS_WIDTH(16), .TICK_DIV(16), .RATE(3),
    .FEE_WIDTH(16), .GATE_CYCLES(3), .PAY_TIMEOUT(10)) u_grace (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_spot(alloc_spot),
    .exit_req(exit_req), .exit_spot(exit_spot), .paid(paid), .exit_busy(g_busy),
    .fee(g_fee), .fee_valid(g_fee_valid), .exit_error(g_err), .gate_open(g_gate),
    .spot_release(g_rel), .occupied(g_occ));

  task automatic do_reset();
    reset = 1'b1; alloc_valid = 1'b0; exit_req = 1'b0; paid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_now(input int t);
    int n = 0;
    while ((cyc / 2) != t && n < 500) begin
      @(negedge clk);
      n++;
    end
    if ((cyc / 2) != t) begin
      checks++; errors++;
      $display("FAIL wait_now: now %0d expected %0d", cyc / 2, t);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_busy, m_fee, m_fee_valid, m_err, m_gate, m_rel, m_occ} !== 28'd0) begin
      errors++; $display("FAIL reset_held: outputs %h expected 0",
        {m_busy, m_fee, m_fee_valid, m_err, m_gate, m_rel, m_occ});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_busy, m_fee, m_fee_valid, m_err, m_gate, m_rel, m_occ} !== 28'd0) begin
      errors++; $display("FAIL reset_released: outputs %h expected 0",
        {m_busy, m_fee, m_fee_valid, m_err, m_gate, m_rel, m_occ});
    end
  endtask

  task automatic test_normal_exit();
    do_reset();
    wait_now(5);
    alloc_valid = 1'b1; alloc_spot = 2'd2;
    @(negedge clk);
    alloc_valid = 1'b0;
    checks++;
    if (m_occ !== 4'b0100) begin errors++; $display("FAIL alloc_occ: got %b expected 0100", m_occ); end
    wait_now(12);
    exit_req = 1'b1; exit_spot = 2'd2;
    @(negedge clk);
    exit_req = 1'b0;
    checks++;
    if ({m_busy, m_fee_valid} !== 2'b10) begin
      errors++; $display("FAIL calc_flags: busy/fee_valid %b expected 10", {m_busy, m_fee_valid});
    end
    @(negedge clk);
    checks++;
    if (m_fee !== 16'd21 || m_fee_valid !== 1'b1) begin
      errors++; $display("FAIL normal_fee: fee %0d valid %b expected 21 1", m_fee, m_fee_valid);
    end
    repeat (2) @(negedge clk);
    paid = 1'b1;
    @(negedge clk);
    paid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_gate !== 1'b1 || m_rel !== 4'b0000 || m_fee_valid !== 1'b0) begin
        errors++; $display("FAIL gate_cycle%0d: gate %b rel %b fee_valid %b expected 1 0000 0",
          i, m_gate, m_rel, m_fee_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (m_gate !== 1'b0 || m_rel !== 4'b0100 || m_occ !== 4'b0000) begin
      errors++; $display("FAIL release: gate %b rel %b occ %b expected 0 0100 0000", m_gate, m_rel, m_occ);
    end
    @(negedge clk);
    checks++;
    if (m_rel !== 4'b0000 || m_busy !== 1'b0) begin
      errors++; $display("FAIL after_release: rel %b busy %b expected 0000 0", m_rel, m_busy);
    end
  endtask

  task automatic test_invalid_ticket();
    do_reset();
    exit_req = 1'b1; exit_spot = 2'd1;
    @(negedge clk);
    exit_req = 1'b0;
    checks++;
    if (m_err !== 1'b1 || m_busy !== 1'b0 || m_fee_valid !== 1'b0) begin
      errors++; $display("FAIL invalid_err: err %b busy %b fee_valid %b expected 1 0 0", m_err, m_busy, m_fee_valid);
    end
    @(negedge clk);
    checks++;
    if ({m_err, m_gate, m_rel, m_busy, m_fee_valid} !== 8'd0) begin
      errors++; $display("FAIL invalid_after: err/gate/rel/busy/fv %b expected 0",
        {m_err, m_gate, m_rel, m_busy, m_fee_valid});
    end
  endtask

  task automatic test_pay_timeout();
    do_reset();
    alloc_valid = 1'b1; alloc_spot = 2'd0;
    @(negedge clk);
    alloc_valid = 1'b0;
    wait_now(4);
    exit_req = 1'b1; exit_spot = 2'd0;
    @(negedge clk);
    exit_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m_fee !== 16'd12 || m_fee_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_fee: fee %0d valid %b expected 12 1", m_fee, m_fee_valid);
    end
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (m_fee_valid !== 1'b1 || m_err !== 1'b0 || m_gate !== 1'b0) begin
        errors++; $display("FAIL wait_pay%0d: fv %b err %b gate %b expected 1 0 0", i, m_fee_valid, m_err, m_gate);
      end
    end
    @(negedge clk);
    checks++;
    if (m_err !== 1'b1 || m_fee_valid !== 1'b0 || m_gate !== 1'b0 || m_occ !== 4'b0001) begin
      errors++; $display("FAIL timeout_err: err %b fv %b gate %b occ %b expected 1 0 0 0001",
        m_err, m_fee_valid, m_gate, m_occ);
    end
    @(negedge clk);
    checks++;
    if (m_err !== 1'b0 || m_gate !== 1'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_after: err %b gate %b busy %b expected 0 0 0", m_err, m_gate, m_busy);
    end
  endtask

  task automatic test_wrap_saturation();
    do_reset();
    wait_now(14);
    alloc_valid = 1'b1; alloc_spot = 2'd1;
    @(negedge clk);
    alloc_valid = 1'b0;
    wait_now(19);
    exit_req = 1'b1; exit_spot = 2'd1;
    @(negedge clk);
    exit_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m_fee !== 16'd15) begin errors++; $display("FAIL main_fee5: got %0d expected 15", m_fee); end
    checks++;
    if (w_fee !== 16'd15 || w_fee_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_fee: fee %0d valid %b expected 15 1", w_fee, w_fee_valid);
    end
    checks++;
    if (s_fee !== 16'hFFFF || s_fee_valid !== 1'b1) begin
      errors++; $display("FAIL sat_fee: fee %h valid %b expected ffff 1", s_fee, s_fee_valid);
    end
  endtask

  task automatic test_grace_and_reset();
    do_reset();
    alloc_valid = 1'b1; alloc_spot = 2'd3;
    @(negedge clk);
    alloc_valid = 1'b0;
    exit_req = 1'b1; exit_spot = 2'd3;
    @(negedge clk);
    exit_req = 1'b0;
    checks++;
    if (g_busy !== 1'b1 || g_gate !== 1'b0) begin
      errors++; $display("FAIL grace_calc: busy %b gate %b expected 1 0", g_busy, g_gate);
    end
    @(negedge clk);
    checks++;
    if (g_gate !== 1'b1 || g_fee_valid !== 1'b0 || g_fee !== 16'd0) begin
      errors++; $display("FAIL grace_gate: gate %b fv %b fee %0d expected 1 0 0", g_gate, g_fee_valid, g_fee);
    end
    @(negedge clk);
    checks++;
    if (g_gate !== 1'b1 || g_occ !== 4'b1000) begin
      errors++; $display("FAIL grace_gate2: gate %b occ %b expected 1 1000", g_gate, g_occ);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (g_gate !== 1'b0 || g_occ !== 4'b0000 || g_rel !== 4'b0000 || g_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: gate %b occ %b rel %b busy %b expected 0 0000 0000 0",
        g_gate, g_occ, g_rel, g_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (g_rel !== 4'b0000 || g_gate !== 1'b0 || g_occ !== 4'b0000) begin
        errors++; $display("FAIL post_reset%0d: rel %b gate %b occ %b expected 0000 0 0000", i, g_rel, g_gate, g_occ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_exit();
    test_invalid_ticket();
    test_pay_timeout();
    test_wrap_saturation();
    test_grace_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
